pixel_cdc_tx: RTL and testbench
===============================

Name: pixel_cdc_tx

Overview:
- CPU-domain transmitter for the CPU->video pixel crossing. It feeds the cpu_pixel_x, cpu_pixel_y, cpu_pixel_brightness and cpu_pixel_shift inputs of the video-side 2-FF synchronizers.
- Accepts DPY pixel requests from the CPU core and buffers them in a small FIFO.
- Presents one pixel at a time on a quasi-static bus: data is stable before, during and after a level strobe. The video domain can therefore sample it safely with plain synchronizers.
- Sits between the CPU core (clk_cpu_fast domain) and the clock domain manager.

Parameters:
- FIFO_DEPTH, 4, pixel request buffer entries; power of 2, at least 2.
- SETUP_CYC, 4, cycles data is stable before shift rises; at least 1.
- STROBE_CYC, 4, cycles shift is held high; at least 1.
- HOLD_CYC, 4, cycles data is held after shift falls; at least 1.
- X_W, 10, X coordinate width.
- Y_W, 10, Y coordinate width.
- B_W, 3, brightness width.

Ports:
- clk_cpu_fast  in  1  51 MHz CPU base clock; the only clock.
- rst_cpu_n  in  1  asynchronous, active-low reset.
- dpy_valid  in  1  one-cycle pixel request from the CPU.
- dpy_x  in  X_W  request X coordinate.
- dpy_y  in  Y_W  request Y coordinate.
- dpy_brightness  in  B_W  request brightness.
- dpy_ready  out  1  high when the FIFO is not full.
- overflow_clr  in  1  clears the sticky overflow flag.
- cpu_pixel_x  out  X_W  X coordinate presented to the synchronizer.
- cpu_pixel_y  out  Y_W  Y coordinate presented to the synchronizer.
- cpu_pixel_brightness  out  B_W  brightness presented to the synchronizer.
- cpu_pixel_shift  out  1  level strobe.
- busy  out  1  high when the FSM is not IDLE or the FIFO is not empty.
- overflow  out  1  sticky; set when a request is dropped.
- drop_cnt  out  8  saturating count of dropped requests.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, except dpy_ready = 1.
  - FIFO empty, FSM in IDLE, all counters 0.
  - Reset mid-transfer aborts the transfer immediately; shift drops to 0 and the in-flight pixel is lost.
- FIFO:
  - Push when dpy_valid and not full.
  - dpy_ready = !full, decoded combinationally from the occupancy count.
  - dpy_valid while full: the request is dropped, even if a pop occurs in the same cycle. overflow is set and drop_cnt increments, saturating at 255.
  - overflow_clr together with a new drop in the same cycle: set wins, overflow stays 1.
  - overflow_clr does not clear drop_cnt; only reset clears it.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; occupancy is tracked by a separate count of log2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, SETUP, STROBE, HOLD. One down-counter, sized for the largest of the three *_CYC parameters.
  - IDLE: if the FIFO is non-empty, pop the head, register it onto the cpu_pixel_* outputs, load SETUP_CYC-1 and go to SETUP. Otherwise stay; outputs keep their last values.
  - SETUP: shift = 0. When the counter reaches 0, load STROBE_CYC-1 and go to STROBE.
  - STROBE: shift = 1. When the counter reaches 0, load HOLD_CYC-1 and go to HOLD.
  - HOLD: shift = 0, data unchanged. When the counter reaches 0:
    - FIFO non-empty: pop, load new data, load SETUP_CYC-1, go to SETUP (back-to-back, no IDLE cycle).
    - FIFO empty: go to IDLE.
- cpu_pixel_shift and all cpu_pixel_* outputs are driven directly from flops: no glitches, no combinational path to the outputs.
- cpu_pixel_x/y/brightness change only on a pop transition, never while shift = 1 and never within SETUP_CYC/HOLD_CYC cycles of a shift edge.
- Latency: push into an empty FIFO with the FSM in IDLE at cycle 0.
  - Data appears on the outputs at cycle 2: write at edge 1, pop and load at edge 2.
  - shift is high from cycle 2+SETUP_CYC for STROBE_CYC cycles.
- Throughput: one pixel per SETUP_CYC+STROBE_CYC+HOLD_CYC cycles, i.e. 12 by default.
- A push and a pop in the same cycle with the FIFO neither full nor empty are both performed; the count is unchanged.

Decomposition:
- Package pixel_cdc_pkg:
  - width localparams for X_W, Y_W, B_W;
  - packed struct pixel_req_t {x, y, brightness};
  - state enum tx_state_t.
- One sub-module, pixel_fifo: synchronous FIFO of pixel_req_t with push, pop, full, empty and count; flop-based storage.
- The top level holds the FSM, the timing counter, the output registers and the overflow/drop logic.

Test Plan:
- Single pixel: after reset, dpy_valid for 1 cycle with x=0x155, y=0x2AA, b=5.
  -> Outputs equal 0x155/0x2AA/5 from cycle 2; shift high in cycles 6-9; busy low from cycle 14; outputs still 0x155/0x2AA/5 in IDLE.
- Back-to-back: 4 pushes on consecutive cycles.
  -> Exactly 4 shift pulses, spaced 12 cycles apart; data changes only on cycles where SETUP is entered; order preserved.
- Overflow: 6 pushes on consecutive cycles with FIFO_DEPTH=4.
  -> 5 pixels transmitted (the first is popped at cycle 2, so the 5th push fits); overflow=1, drop_cnt=1, dpy_ready low while the FIFO holds 4.
- Saturation and clear: 300 drops, then overflow_clr coincident with a drop, then overflow_clr alone.
  -> drop_cnt=255; overflow stays 1 after the coincident clear and goes to 0 after the lone clear.
- Reset mid-STROBE: assert rst_cpu_n low while shift=1.
  -> shift and all data outputs 0 immediately (asynchronous); FIFO empty, dpy_ready=1, busy=0 after release.
- Stability checker (continuous): any change on cpu_pixel_x/y/brightness within SETUP_CYC cycles before a shift rise, while shift=1, or within HOLD_CYC cycles after a shift fall -> assertion failure.

Source files
------------

// File: rtl/pixel_cdc_pkg.sv
// Shared types for the CPU->video pixel transmitter: request record and FSM states.
package pixel_cdc_pkg;

    localparam int PX_X_W = 10;
    localparam int PX_Y_W = 10;
    localparam int PX_B_W = 3;

    typedef struct packed {
        logic [PX_X_W-1:0] x;
        logic [PX_Y_W-1:0] y;
        logic [PX_B_W-1:0] brightness;
    } pixel_req_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } tx_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Flop-based synchronous FIFO of pixel requests; occupancy held in a separate counter.
module pixel_fifo
    import pixel_cdc_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  pixel_req_t wdata,
    input  logic       pop,
    output pixel_req_t rdata,
    output logic       full,
    output logic       empty,
    output logic [AW:0] count
);

    pixel_req_t    mem_q [DEPTH];
    pixel_req_t    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pixel_cdc_tx.sv
// CPU-side pixel transmitter: buffers requests and presents each one as a
// quasi-static bus framed by setup / strobe / hold phases for 2-FF sampling.
module pixel_cdc_tx
    import pixel_cdc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 4,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 4,
    parameter int X_W        = PX_X_W,
    parameter int Y_W        = PX_Y_W,
    parameter int B_W        = PX_B_W
) (
    input  logic           clk_cpu_fast,
    input  logic           rst_cpu_n,
    input  logic           dpy_valid,
    input  logic [X_W-1:0] dpy_x,
    input  logic [Y_W-1:0] dpy_y,
    input  logic [B_W-1:0] dpy_brightness,
    output logic           dpy_ready,
    input  logic           overflow_clr,
    output logic [X_W-1:0] cpu_pixel_x,
    output logic [Y_W-1:0] cpu_pixel_y,
    output logic [B_W-1:0] cpu_pixel_brightness,
    output logic           cpu_pixel_shift,
    output logic           busy,
    output logic           overflow,
    output logic [7:0]     drop_cnt
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [B_W-1:0]   b_q, b_d;
    logic             shift_q, shift_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    pixel_req_t  fifo_wdata, fifo_head;
    logic        fifo_pop, fifo_full, fifo_empty, drop;
    logic [AW:0] fifo_count;

    assign fifo_wdata = '{x: PX_X_W'(dpy_x), y: PX_Y_W'(dpy_y), brightness: PX_B_W'(dpy_brightness)};

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_cpu_fast),
        .rst_n (rst_cpu_n),
        .push  (dpy_valid),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk_cpu_fast or negedge rst_cpu_n) begin
        if (!rst_cpu_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            b_q        <= '0;
            shift_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            b_q        <= b_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cnt_d    = SETUP_LD;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = STROBE_LD;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    cnt_d   = HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    // Chain straight into the next pixel when one is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        cnt_d    = SETUP_LD;
                        state_d  = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d = (state_d == ST_STROBE);
        x_d     = x_q;
        y_d     = y_q;
        b_d     = b_q;
        if (fifo_pop) begin
            x_d = X_W'(fifo_head.x);
            y_d = Y_W'(fifo_head.y);
            b_d = B_W'(fifo_head.brightness);
        end
        // A request seen while full is lost even if a pop frees a slot this cycle.
        drop       = dpy_valid && fifo_full;
        overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
        drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    assign dpy_ready            = (fifo_count != (AW+1)'(FIFO_DEPTH));
    assign busy                 = (state_q != ST_IDLE) || !fifo_empty;
    assign cpu_pixel_x          = x_q;
    assign cpu_pixel_y          = y_q;
    assign cpu_pixel_brightness = b_q;
    assign cpu_pixel_shift      = shift_q;
    assign overflow             = overflow_q;
    assign drop_cnt             = drop_cnt_q;

endmodule

// File: tb/tb_pixel_cdc_tx.sv
// Directed bench for pixel_cdc_tx: table-driven single-pixel timing plus
// sequences for back-to-back, overflow, saturation/clear and mid-strobe reset.
module tb_pixel_cdc_tx;
    import pixel_cdc_pkg::*;

    localparam int SETUP_CYC = 4;
    localparam int HOLD_CYC  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dpy_valid = 1'b0;
    logic [9:0] dpy_x = '0;
    logic [9:0] dpy_y = '0;
    logic [2:0] dpy_brightness = '0;
    logic       overflow_clr = 1'b0;
    logic       dpy_ready, cpu_pixel_shift, busy, overflow;
    logic [9:0] cpu_pixel_x, cpu_pixel_y;
    logic [2:0] cpu_pixel_brightness;
    logic [7:0] drop_cnt;

    int passed = 0;
    int total  = 0;

    pixel_cdc_tx dut (
        .clk_cpu_fast         (clk),
        .rst_cpu_n            (rst_n),
        .dpy_valid            (dpy_valid),
        .dpy_x                (dpy_x),
        .dpy_y                (dpy_y),
        .dpy_brightness       (dpy_brightness),
        .dpy_ready            (dpy_ready),
        .overflow_clr         (overflow_clr),
        .cpu_pixel_x          (cpu_pixel_x),
        .cpu_pixel_y          (cpu_pixel_y),
        .cpu_pixel_brightness (cpu_pixel_brightness),
        .cpu_pixel_shift      (cpu_pixel_shift),
        .busy                 (busy),
        .overflow             (overflow),
        .drop_cnt             (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       shift;
        logic       busy;
        logic       ready;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] b;
    } vec_t;

    localparam int NSP = 10;
    vec_t       sp [NSP];
    pixel_req_t px_tab [8];
    int         rise_cyc [$];
    logic [22:0] rise_dat [$];
    int         chg_cyc [$];
    logic       rdy_log [80];
    logic       ovf_log [80];
    logic [7:0] dc_log [80];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] bus();
        return {cpu_pixel_x, cpu_pixel_y, cpu_pixel_brightness};
    endfunction

    // Continuous stability monitor on the data bus around the strobe.
    logic prev_shift = 1'b0;
    logic [22:0] prev_bus = '0;
    int since_fall = 1000;
    int since_chg  = 1000;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_shift = 1'b0;
            prev_bus   = '0;
            since_fall = 1000;
            since_chg  = 1000;
        end else begin
            since_fall++;
            since_chg++;
            if (prev_shift && !cpu_pixel_shift) since_fall = 0;
            if (bus() !== prev_bus) begin
                chk("stab_data_change", {31'd0, !cpu_pixel_shift && (since_fall >= HOLD_CYC)}, 32'd1);
                since_chg = 0;
            end
            if (!prev_shift && cpu_pixel_shift)
                chk("stab_setup_before_rise", {31'd0, since_chg >= SETUP_CYC}, 32'd1);
            prev_shift = cpu_pixel_shift;
            prev_bus   = bus();
        end
    end

    task automatic run(input int n, input int ncyc);
        logic ps;
        logic [22:0] pd;
        rise_cyc.delete();
        rise_dat.delete();
        chg_cyc.delete();
        ps = cpu_pixel_shift;
        pd = bus();
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) step();
            dpy_valid = (c < n);
            if (c < n) {dpy_x, dpy_y, dpy_brightness} = px_tab[c];
            rdy_log[c] = dpy_ready;
            ovf_log[c] = overflow;
            dc_log[c]  = drop_cnt;
            if (cpu_pixel_shift && !ps) begin
                rise_cyc.push_back(c);
                rise_dat.push_back(bus());
            end
            if (bus() !== pd) chg_cyc.push_back(c);
            ps = cpu_pixel_shift;
            pd = bus();
        end
        step();
        dpy_valid = 1'b0;
    endtask

    initial begin
        bit found;

        sp[0] = '{0,  1'b0, 1'b0, 1'b1, 10'h000, 10'h000, 3'd0};
        sp[1] = '{1,  1'b0, 1'b1, 1'b1, 10'h000, 10'h000, 3'd0};
        sp[2] = '{2,  1'b0, 1'b1, 1'b1, 10'h155, 10'h2AA, 3'd5};
        sp[3] = '{5,  1'b0, 1'b1, 1'b1, 10'h155, 10'h2AA, 3'd5};
        sp[4] = '{6,  1'b1, 1'b1, 1'b1, 10'h155, 10'h2AA, 3'd5};
        sp[5] = '{9,  1'b1, 1'b1, 1'b1, 10'h155, 10'h2AA, 3'd5};
        sp[6] = '{10, 1'b0, 1'b1, 1'b1, 10'h155, 10'h2AA, 3'd5};
        sp[7] = '{13, 1'b0, 1'b1, 1'b1, 10'h155, 10'h2AA, 3'd5};
        sp[8] = '{14, 1'b0, 1'b0, 1'b1, 10'h155, 10'h2AA, 3'd5};
        sp[9] = '{16, 1'b0, 1'b0, 1'b1, 10'h155, 10'h2AA, 3'd5};

        // Reset state
        step();
        step();
        chk("rst_ready", {31'd0, dpy_ready}, 32'd1);
        chk("rst_shift", {31'd0, cpu_pixel_shift}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bus", {9'd0, bus()}, 32'd0);
        chk("rst_ovf_cnt", {23'd0, overflow, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        step();
        step();

        // Single pixel, checked against the timing table
        dpy_valid = 1'b1;
        dpy_x = 10'h155;
        dpy_y = 10'h2AA;
        dpy_brightness = 3'd5;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) begin
                step();
                dpy_valid = 1'b0;
            end
            for (int k = 0; k < NSP; k++) begin
                if (sp[k].cyc == c) begin
                    chk($sformatf("sp_c%0d_shift", c), {31'd0, cpu_pixel_shift}, {31'd0, sp[k].shift});
                    chk($sformatf("sp_c%0d_busy", c), {31'd0, busy}, {31'd0, sp[k].busy});
                    chk($sformatf("sp_c%0d_ready", c), {31'd0, dpy_ready}, {31'd0, sp[k].ready});
                    chk($sformatf("sp_c%0d_bus", c), {9'd0, bus()}, {9'd0, sp[k].x, sp[k].y, sp[k].b});
                end
            end
        end

        // Back-to-back: four pushes on consecutive cycles
        px_tab[0] = '{10'h001, 10'h011, 3'd1};
        px_tab[1] = '{10'h002, 10'h022, 3'd2};
        px_tab[2] = '{10'h003, 10'h033, 3'd3};
        px_tab[3] = '{10'h004, 10'h044, 3'd4};
        run(4, 60);
        chk("b2b_rises", rise_cyc.size(), 32'd4);
        chk("b2b_changes", chg_cyc.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rise_cyc.size()) begin
                chk($sformatf("b2b_rise%0d_cyc", i), rise_cyc[i], 6 + 12 * i);
                chk($sformatf("b2b_rise%0d_dat", i), {9'd0, rise_dat[i]}, {9'd0, px_tab[i]});
            end
            if (i < chg_cyc.size())
                chk($sformatf("b2b_chg%0d_cyc", i), chg_cyc[i], 2 + 12 * i);
        end
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        // Overflow: six pushes into a four-entry FIFO
        for (int i = 0; i < 6; i++) px_tab[i] = '{10'(16 * i + 9), 10'(3 * i + 100), 3'(i + 1)};
        run(6, 70);
        chk("ovf_rises", rise_cyc.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < rise_dat.size())
                chk($sformatf("ovf_rise%0d_dat", i), {9'd0, rise_dat[i]}, {9'd0, px_tab[i]});
        chk("ovf_ready_c4", {31'd0, rdy_log[4]}, 32'd1);
        chk("ovf_ready_c5", {31'd0, rdy_log[5]}, 32'd0);
        chk("ovf_ready_c13", {31'd0, rdy_log[13]}, 32'd0);
        chk("ovf_ready_c14", {31'd0, rdy_log[14]}, 32'd1);
        chk("ovf_flag_c5", {31'd0, ovf_log[5]}, 32'd0);
        chk("ovf_flag_c6", {31'd0, ovf_log[6]}, 32'd1);
        chk("ovf_cnt_c6", {24'd0, dc_log[6]}, 32'd1);
        chk("ovf_cnt_end", {24'd0, dc_log[69]}, 32'd1);

        // Saturation: hold a request for 300 cycles against a mostly-full FIFO
        dpy_valid = 1'b1;
        {dpy_x, dpy_y, dpy_brightness} = 23'h12345;
        for (int c = 0; c < 300; c++) step();
        chk("sat_cnt", {24'd0, drop_cnt}, 32'd255);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (!dpy_ready) found = 1'b1;
            else step();
        end
        chk("sat_full_seen", {31'd0, found}, 32'd1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        dpy_valid = 1'b0;
        chk("clr_with_drop_ovf", {31'd0, overflow}, 32'd1);
        chk("clr_with_drop_cnt", {24'd0, drop_cnt}, 32'd255);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("clr_alone_ovf", {31'd0, overflow}, 32'd0);
        chk("clr_alone_cnt", {24'd0, drop_cnt}, 32'd255);

        // Reset while the strobe is high
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (cpu_pixel_shift) found = 1'b1;
            else step();
        end
        chk("mid_strobe_seen", {31'd0, found}, 32'd1);
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_shift", {31'd0, cpu_pixel_shift}, 32'd0);
        chk("mid_rst_bus", {9'd0, bus()}, 32'd0);
        chk("mid_rst_ready", {31'd0, dpy_ready}, 32'd1);
        chk("mid_rst_cnt", {24'd0, drop_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_ready", {31'd0, dpy_ready}, 32'd1);
        chk("post_rst_shift", {31'd0, cpu_pixel_shift}, 32'd0);
        chk("post_rst_ovf", {31'd0, overflow}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
